biset_master: RTL
=================

BISET_MASTER -- requirements
Module: biset_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, meaning the number of cycles from a read command on setCtrl_o to valid data on setReply_i (range 1..15).
REQ-002 SHALL have parameter WRITE_GAP, default 0, meaning the number of idle bus cycles inserted after every write (range 0..15).
REQ-003 clk_i  input  1  clock; single clock domain.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 req_valid_i  input  1  request offered.
REQ-006 req_ready_o  output  1  request accepted when both valid and ready are high.
REQ-007 req_write_i  input  1  1 = write, 0 = read.
REQ-008 req_addr_i  input  BiSet::BISET_ADDR_W  target register address.
REQ-009 req_data_i  input  32  write data; ignored for reads.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumed when both valid and ready are high.
REQ-012 rsp_data_o  output  32  read data; 0 for write acknowledgements.
REQ-013 rsp_write_o  output  1  response belongs to a write.
REQ-014 setCtrl_o  output  BiSet::biSetCtrl  bus command to all responders.
REQ-015 setReply_i  input  BiSet::biSetReply  OR-combined responder replies.
REQ-016 busy_o  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT, RESP and GAP.
REQ-018 IDLE: req_ready_o=1; on handshake, latch write/addr/data and go to ISSUE.
REQ-019 ISSUE: drive setCtrl_o with latched addr/data/write enable for exactly one cycle.
REQ-020 ISSUE transitions: read -> WAIT; write -> RESP if write ack is enabled, else GAP if WRITE_GAP>0, else IDLE.
REQ-021 In every state other than ISSUE, setCtrl_o SHALL equal BiSet::BISET_CTRL_IDLE, so that no responder sees a spurious read.
REQ-022 WAIT: a 4-bit counter loads READ_LATENCY-1 in ISSUE and decrements each cycle.
REQ-023 WAIT exit: when the counter is 0, capture the reply data from setReply_i into a 32-bit register and go to RESP.
REQ-024 For READ_LATENCY=1, capture SHALL occur in the cycle directly after ISSUE.
REQ-025 RESP: rsp_valid_o=1 and rsp_data_o/rsp_write_o stable until handshake; on handshake go to GAP (write with WRITE_GAP>0) or IDLE.
REQ-026 GAP: counts WRITE_GAP cycles, then goes to IDLE.
REQ-027 Exactly one transaction SHALL be outstanding; req_ready_o=0 outside IDLE.
REQ-028 Request-to-command latency SHALL be 1 cycle (handshake in cycle N, command in N+1); minimum read turnaround is READ_LATENCY+2 cycles.
REQ-029 A reply value of 0 is valid data (unmapped address reads 0); no error reporting.
REQ-030 setReply_i SHALL be sampled only in the capture cycle; other-cycle values are ignored.

Reset
REQ-031 rst_i SHALL force IDLE, clear all counters and registers, and set req_ready_o=0 during reset and 1 in the first cycle after.
REQ-032 Reset outputs: rsp_valid_o=0, rsp_data_o=0, rsp_write_o=0, busy_o=0, setCtrl_o=BISET_CTRL_IDLE.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no response, and setCtrl_o SHALL be idle in the reset cycle.

Configuration
REQ-034 With BISET_MASTER_WRITE_ACK_EN defined, every write SHALL produce one response (rsp_write_o=1, rsp_data_o=0).
REQ-035 Without BISET_MASTER_WRITE_ACK_EN, writes SHALL produce no response and rsp_write_o SHALL be tied to 0.

Structure
REQ-036 BiSet package SHALL hold BISET_ADDR_W, BISET_CTRL_IDLE, constructor functions BiSetCtrlRead(addr) and BiSetCtrlWrite(addr,data), and extractor BiSetReplyData(reply).
REQ-037 State enum SHALL be local to the module; no sub-module is required.

Verification
REQ-038 Read addr 5 with a counter responder (ADDR=5) pulsed 3 times -> one ISSUE cycle, rsp_data_o=3; a second read gives 0.
REQ-039 READ_LATENCY=3 with a delayed responder returning 0xA5A5_0001 -> capture exactly 3 cycles after ISSUE; a 0xFFFF_FFFF value on the bus 1 cycle earlier is ignored.
REQ-040 Write addr 2 data 0x1234 with ack enabled -> one response (rsp_write_o=1, data 0); without the macro -> no response and IDLE 1 cycle after ISSUE.
REQ-041 rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable, req_ready_o=0, setCtrl_o idle throughout.
REQ-042 WRITE_GAP=4, back-to-back writes offered -> commands at least 5 cycles apart.
REQ-043 rst_i asserted during WAIT -> no response emitted, IDLE next cycle, next read completes normally.

Source files
------------

// File: rtl/biset_master_pkg.sv
// BiSet bus package: address width, command/reply structures and the helpers
// masters and responders use to build commands and unpack replies.
package BiSet;

    localparam int BISET_ADDR_W = 8;

    typedef struct packed {
        logic                    rd;
        logic                    wr;
        logic [BISET_ADDR_W-1:0] addr;
        logic [31:0]             data;
    } biSetCtrl;

    typedef struct packed {
        logic [31:0] data;
    } biSetReply;

    localparam biSetCtrl BISET_CTRL_IDLE = '{rd: 1'b0, wr: 1'b0, addr: '0, data: '0};

    function automatic biSetCtrl BiSetCtrlRead(input logic [BISET_ADDR_W-1:0] addr);
        biSetCtrl c;
        c      = BISET_CTRL_IDLE;
        c.rd   = 1'b1;
        c.addr = addr;
        return c;
    endfunction

    function automatic biSetCtrl BiSetCtrlWrite(input logic [BISET_ADDR_W-1:0] addr,
                                                input logic [31:0] data);
        biSetCtrl c;
        c      = BISET_CTRL_IDLE;
        c.wr   = 1'b1;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

    function automatic logic [31:0] BiSetReplyData(input biSetReply reply);
        return reply.data;
    endfunction

endpackage

// File: rtl/biset_master.sv
// Single-outstanding BiSet bus master bridging a valid/ready request/response pair.
// Define BISET_MASTER_WRITE_ACK_EN to make every write return an acknowledgement response.
module biset_master
    import BiSet::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_GAP    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [BISET_ADDR_W-1:0] req_addr_i,
    input  logic [31:0]             req_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_write_o,
    output biSetCtrl                setCtrl_o,
    input  biSetReply               setReply_i,
    output logic                    busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [3:0] RD_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD = 4'(WRITE_GAP - 1);
    localparam bit         GAP_EN   = (WRITE_GAP > 0);
`ifdef BISET_MASTER_WRITE_ACK_EN
    localparam bit         ACK_EN   = 1'b1;
`else
    localparam bit         ACK_EN   = 1'b0;
`endif

    logic [2:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [BISET_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_ISSUE;
                    wr_d    = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_write_i ? req_data_i : 32'd0;
                end
            end
            S_ISSUE: begin
                if (!wr_q) begin
                    state_d = S_WAIT;
                    cnt_d   = RD_LOAD;
                end else begin
                    // Write acknowledgements always carry zero data.
                    rdata_d = 32'd0;
                    if (ACK_EN) begin
                        state_d = S_RESP;
                    end else if (GAP_EN) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                // The reply bus is only looked at in this single capture cycle.
                if (cnt_q == 4'd0) begin
                    rdata_d = BiSetReplyData(setReply_i);
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    if (wr_q && GAP_EN) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs are gated by rst_i so the reset cycle itself is already quiet.
    assign req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign rsp_valid_o = (state_q == S_RESP) && !rst_i;
    assign busy_o      = (state_q != S_IDLE) && !rst_i;
    assign rsp_data_o  = rdata_q;

`ifdef BISET_MASTER_WRITE_ACK_EN
    assign rsp_write_o = (state_q == S_RESP) && wr_q && !rst_i;
`else
    assign rsp_write_o = 1'b0;
`endif

    always_comb begin
        setCtrl_o = BISET_CTRL_IDLE;
        if ((state_q == S_ISSUE) && !rst_i) begin
            setCtrl_o = wr_q ? BiSetCtrlWrite(addr_q, wdata_q) : BiSetCtrlRead(addr_q);
        end
    end

endmodule
